systolic_pe_param: RTL and testbench
====================================

Name: systolic_pe_param

Overview:
- Parametrised next-generation systolic processing element.
- Each cycle it forwards A operands east and B operands south with a one-cycle register stage.
- It accumulates a signed dot product of K_LEN valid operand pairs, then emits the result with a one-cycle valid pulse and a per-tile overflow flag.
- Adds configurable widths, tile length, saturate/wrap mode and a synchronous tile clear, all of which the prior PE lacked.

Parameters:
- DATA_W, 8: signed operand width.
- ACC_W, 32: signed accumulator/result width; must be >= 2*DATA_W.
- K_LEN, 4: valid operand pairs per output tile; must be >= 1.
- SATURATE, 1: 1 = clamp accumulator on signed overflow; 0 = two's-complement wrap.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous tile abort: discards partial sum and count.
- valid_in  in  1  a_in/b_in carry a valid operand pair this cycle.
- a_in  in  DATA_W  signed operand A from west neighbour.
- b_in  in  DATA_W  signed operand B from north neighbour.
- a_out  out  DATA_W  registered A to east neighbour.
- b_out  out  DATA_W  registered B to south neighbour.
- valid_out  out  1  registered valid_in to neighbours.
- y_out  out  ACC_W  signed completed tile result.
- y_valid  out  1  one-cycle pulse: y_out/overflow updated.
- overflow  out  1  any overflow occurred in the tile reported with y_out.

Behaviour:
- Reset (asynchronous, active-high): all outputs 0; accumulator 0; count 0; sticky overflow 0; FSM to IDLE. Reset may assert mid-tile; partial tile is lost and no y_valid is emitted.
- Forwarding path:
  - valid_out <= valid_in every cycle (latency 1).
  - a_out/b_out load a_in/b_in only when valid_in=1; otherwise they hold.
  - Forwarding is unaffected by clear.
- Arithmetic:
  - prod = a_in*b_in, signed, full 2*DATA_W bits, sign-extended to ACC_W.
  - sum = acc + prod, computed at ACC_W+1 bits.
  - Overflow when the two MSBs of sum differ.
  - SATURATE=1: result clamps to +2^(ACC_W-1)-1 (positive) or -2^(ACC_W-1) (negative).
  - SATURATE=0: result is the low ACC_W bits.
  - Any overflow sets the sticky overflow bit for the current tile.
- FSM states IDLE, ACCUM:
  - IDLE: acc=0, count=0.
    - valid_in and K_LEN>1: acc<=result, count<=1, go to ACCUM.
    - valid_in and K_LEN==1: complete the tile immediately and stay in IDLE.
  - ACCUM, on valid_in:
    - count<K_LEN-1: acc<=result, count<=count+1.
    - count==K_LEN-1 (final pair): y_out<=result, overflow<=sticky|this_ovf, y_valid<=1 next cycle; then acc, count and sticky clear, go to IDLE.
  - ACCUM, valid_in=0: hold all state. Gaps of any length are legal.
- y_valid is high exactly one cycle per completed tile.
- y_out and overflow hold their values between completions.
- Back-to-back tiles are legal: the first pair of tile N+1 may arrive the cycle after the last pair of tile N, with no bubble.
- clear=1: acc, count and sticky go to 0, FSM goes to IDLE; y_out and overflow hold.
- clear and valid_in in the same cycle: clear wins. The pair is forwarded but not accumulated, and no y_valid is produced.
- The clear/valid_in rule also applies when that pair would have been the final pair of the tile.

Optional Feature:
- Macro PE_TILE_CNT_EN.
- Defined: adds output tile_cnt [15:0]. It is 0 on reset and increments on every y_valid, wrapping 65535 -> 0. clear does not affect it.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Basic tile (defaults): a=3, b=-2 on 4 consecutive valid cycles -> y_valid pulses one cycle after the 4th pair, y_out=-24, overflow=0. a_out=3, b_out=-2, valid_out lagging valid_in by 1 cycle.
- Gapped input: same 4 pairs with valid_in low for 1, 3 and 0 cycles between them -> identical result -24. a_out/b_out hold during gaps.
- Saturation: ACC_W=16, SATURATE=1, a=b=127 x4 -> y_out=32767, overflow=1. With SATURATE=0 -> y_out=-1020, overflow=1. The next tile a=b=1 x4 -> y_out=4, overflow=0.
- Clear mid-tile: 2 pairs (5,5), then clear together with pair (1,1), then 4 pairs (1,1) -> y_out=4, exactly one y_valid, and valid_out=1 for the cleared cycle.
- Reset mid-tile: 3 pairs, then asynchronous reset pulse between clock edges -> all outputs read 0 immediately. The next 4 pairs (2,2) give y_out=16.
- Back-to-back and K_LEN=1: K_LEN=1, pairs (2,3), (-4,4), (7,-1) consecutive -> y_out=6, -16, -7 with y_valid high 3 consecutive cycles. With PE_TILE_CNT_EN, tile_cnt reads 3.

Source files
------------

// File: rtl/systolic_pe_param.sv
// rtl/systolic_pe_param.sv - parametrised systolic PE: forwards A/B and accumulates signed K_LEN-pair tiles
// Optional output tile_cnt is present only when PE_TILE_CNT_EN is defined.
module systolic_pe_param #(
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 32,
  parameter int K_LEN    = 4,
  parameter int SATURATE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic              valid_out,
  output logic [ACC_W-1:0]  y_out,
  output logic              y_valid,
`ifdef PE_TILE_CNT_EN
  output logic              overflow,
  output logic [15:0]       tile_cnt
`else
  output logic              overflow
`endif
);

  localparam int CNT_W = (K_LEN > 1) ? $clog2(K_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(K_LEN - 1);
  localparam logic [ACC_W-1:0] SAT_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SAT_MIN  = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t             state, state_d;
  logic [ACC_W-1:0]   acc, acc_d;
  logic [CNT_W-1:0]   count, count_d;
  logic               sticky, sticky_d;
  logic               done;

  logic signed [2*DATA_W-1:0] prod;
  logic [ACC_W:0]             prod_ext;
  logic [ACC_W:0]             sum;
  logic                       ovf;
  logic [ACC_W-1:0]           result;
  logic                       last_pair;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_out     <= '0;
      b_out     <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= valid_in;
      if (valid_in) begin
        a_out <= a_in;
        b_out <= b_in;
      end
    end
  end

  // acc is held at zero while IDLE, so the first pair of a tile needs no special add path
  assign prod     = $signed(a_in) * $signed(b_in);
  assign prod_ext = {{(ACC_W+1-2*DATA_W){prod[2*DATA_W-1]}}, prod};
  assign sum      = {acc[ACC_W-1], acc} + prod_ext;
  assign ovf      = sum[ACC_W] ^ sum[ACC_W-1];

  always_comb begin
    result = sum[ACC_W-1:0];
    if ((SATURATE != 0) && ovf) begin
      result = sum[ACC_W] ? SAT_MIN : SAT_MAX;
    end
  end

  assign last_pair = (K_LEN == 1) || ((state == ACCUM) && (count == LAST_CNT));

  always_comb begin
    state_d  = state;
    acc_d    = acc;
    count_d  = count;
    sticky_d = sticky;
    done     = 1'b0;
    if (clear) begin
      state_d  = IDLE;
      acc_d    = '0;
      count_d  = '0;
      sticky_d = 1'b0;
    end else if (valid_in) begin
      if (last_pair) begin
        done     = 1'b1;
        state_d  = IDLE;
        acc_d    = '0;
        count_d  = '0;
        sticky_d = 1'b0;
      end else begin
        state_d  = ACCUM;
        acc_d    = result;
        count_d  = count + CNT_W'(1);
        sticky_d = sticky | ovf;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      acc    <= '0;
      count  <= '0;
      sticky <= 1'b0;
    end else begin
      state  <= state_d;
      acc    <= acc_d;
      count  <= count_d;
      sticky <= sticky_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y_out    <= '0;
      overflow <= 1'b0;
      y_valid  <= 1'b0;
    end else begin
      y_valid <= done;
      if (done) begin
        y_out    <= result;
        overflow <= sticky | ovf;
      end
    end
  end

`ifdef PE_TILE_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tile_cnt <= '0;
    end else if (y_valid) begin
      tile_cnt <= tile_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_systolic_pe_param.sv
// tb/tb_systolic_pe_param.sv - directed table-driven bench for systolic_pe_param
// Four instances share stimulus: defaults, 16-bit saturate, 16-bit wrap, K_LEN=1.
module tb_systolic_pe_param;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clear = 1'b0;
  logic valid_in = 1'b0;
  logic signed [7:0] a_in = '0;
  logic signed [7:0] b_in = '0;

  logic [7:0]  d_a, d_b, s_a, s_b, w_a, w_b, k_a, k_b;
  logic        d_vo, s_vo, w_vo, k_vo;
  logic [31:0] d_y, k_y;
  logic [15:0] s_y, w_y;
  logic        d_yv, s_yv, w_yv, k_yv;
  logic        d_ov, s_ov, w_ov, k_ov;
`ifdef PE_TILE_CNT_EN
  logic [15:0] d_tc, s_tc, w_tc, k_tc;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  systolic_pe_param u_def (
    .clk(clk), .reset(reset), .clear(clear), .valid_in(valid_in), .a_in(a_in), .b_in(b_in),
    .a_out(d_a), .b_out(d_b), .valid_out(d_vo), .y_out(d_y), .y_valid(d_yv),
`ifdef PE_TILE_CNT_EN
    .tile_cnt(d_tc),
`endif
    .overflow(d_ov));

  systolic_pe_param #(.ACC_W(16), .SATURATE(1)) u_sat (
    .clk(clk), .reset(reset), .clear(clear), .valid_in(valid_in), .a_in(a_in), .b_in(b_in),
    .a_out(s_a), .b_out(s_b), .valid_out(s_vo), .y_out(s_y), .y_valid(s_yv),
`ifdef PE_TILE_CNT_EN
    .tile_cnt(s_tc),
`endif
    .overflow(s_ov));

  systolic_pe_param #(.ACC_W(16), .SATURATE(0)) u_wrap (
    .clk(clk), .reset(reset), .clear(clear), .valid_in(valid_in), .a_in(a_in), .b_in(b_in),
    .a_out(w_a), .b_out(w_b), .valid_out(w_vo), .y_out(w_y), .y_valid(w_yv),
`ifdef PE_TILE_CNT_EN
    .tile_cnt(w_tc),
`endif
    .overflow(w_ov));

  systolic_pe_param #(.K_LEN(1)) u_k1 (
    .clk(clk), .reset(reset), .clear(clear), .valid_in(valid_in), .a_in(a_in), .b_in(b_in),
    .a_out(k_a), .b_out(k_b), .valid_out(k_vo), .y_out(k_y), .y_valid(k_yv),
`ifdef PE_TILE_CNT_EN
    .tile_cnt(k_tc),
`endif
    .overflow(k_ov));

  typedef struct {
    logic              clr;
    logic              v;
    logic signed [7:0] a;
    logic signed [7:0] b;
    logic              evo;
    logic signed [7:0] ea;
    logic signed [7:0] eb;
    logic              eyv;
    int                ey;
    logic              eov;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic clr, input logic v, input int a, input int b,
                     input logic evo, input int ea, input int eb,
                     input logic eyv, input int ey, input logic eov);
    vec_t t;
    t.clr = clr; t.v = v; t.a = 8'(a); t.b = 8'(b);
    t.evo = evo; t.ea = 8'(ea); t.eb = 8'(eb);
    t.eyv = eyv; t.ey = ey; t.eov = eov;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic clr, input logic v, input int a, input int b);
    @(negedge clk);
    clear = clr; valid_in = v; a_in = 8'(a); b_in = 8'(b);
    @(posedge clk);
    #1;
  endtask

  task automatic async_reset();
    @(negedge clk);
    clear = 1'b0; valid_in = 1'b0;
    #2 reset = 1'b1;
    #1;
  endtask

  task automatic release_reset();
    #1 reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // basic tile, then hold
    for (int i = 0; i < 4; i++) add(0, 1, 3, -2, 1, 3, -2, i == 3, (i == 3) ? -24 : 0, 0);
    add(0, 0, 9, 9, 0, 3, -2, 0, -24, 0);
    // gapped tile: gaps of 1, 3, 0
    add(0, 1, 3, -2, 1, 3, -2, 0, -24, 0);
    add(0, 0, 9, 9, 0, 3, -2, 0, -24, 0);
    add(0, 1, 3, -2, 1, 3, -2, 0, -24, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 9, 9, 0, 3, -2, 0, -24, 0);
    add(0, 1, 3, -2, 1, 3, -2, 0, -24, 0);
    add(0, 1, 3, -2, 1, 3, -2, 1, -24, 0);
    add(0, 0, 0, 0, 0, 3, -2, 0, -24, 0);
    // clear mid-tile together with a pair
    add(0, 1, 5, 5, 1, 5, 5, 0, -24, 0);
    add(0, 1, 5, 5, 1, 5, 5, 0, -24, 0);
    add(1, 1, 1, 1, 1, 1, 1, 0, -24, 0);
    for (int i = 0; i < 4; i++) add(0, 1, 1, 1, 1, 1, 1, i == 3, (i == 3) ? 4 : -24, 0);
    add(0, 0, 0, 0, 0, 1, 1, 0, 4, 0);
    // clear on what would be the final pair
    for (int i = 0; i < 3; i++) add(0, 1, 2, 2, 1, 2, 2, 0, 4, 0);
    add(1, 1, 2, 2, 1, 2, 2, 0, 4, 0);
    add(0, 0, 0, 0, 0, 2, 2, 0, 4, 0);
    for (int i = 0; i < 4; i++) add(0, 1, 1, 2, 1, 1, 2, i == 3, (i == 3) ? 8 : 4, 0);
    add(0, 0, 0, 0, 0, 1, 2, 0, 8, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("reset a_out", d_a, 0);
    chk("reset b_out", d_b, 0);
    chk("reset valid_out", d_vo, 0);
    chk("reset y_out", d_y, 0);
    chk("reset y_valid", d_yv, 0);
    chk("reset overflow", d_ov, 0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      step(vecs[i].clr, vecs[i].v, vecs[i].a, vecs[i].b);
      chk($sformatf("vec%0d valid_out", i), d_vo, vecs[i].evo);
      chk($sformatf("vec%0d a_out", i), $signed(d_a), vecs[i].ea);
      chk($sformatf("vec%0d b_out", i), $signed(d_b), vecs[i].eb);
      chk($sformatf("vec%0d y_valid", i), d_yv, vecs[i].eyv);
      chk($sformatf("vec%0d y_out", i), $signed(d_y), vecs[i].ey);
      chk($sformatf("vec%0d overflow", i), d_ov, vecs[i].eov);
    end

    // asynchronous reset mid-tile
    for (int i = 0; i < 3; i++) step(0, 1, 4, 4);
    async_reset();
    chk("midreset a_out", d_a, 0);
    chk("midreset b_out", d_b, 0);
    chk("midreset valid_out", d_vo, 0);
    chk("midreset y_out", d_y, 0);
    chk("midreset overflow", d_ov, 0);
    chk("midreset y_valid", d_yv, 0);
    release_reset();
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 2, 2);
      chk($sformatf("postreset y_valid %0d", i), d_yv, i == 3);
    end
    chk("postreset y_out", $signed(d_y), 16);
    step(0, 0, 0, 0);
    chk("postreset y_valid drop", d_yv, 0);

    // saturate vs wrap at ACC_W=16
    async_reset();
    release_reset();
    for (int i = 0; i < 4; i++) step(0, 1, 127, 127);
    chk("sat y_valid", s_yv, 1);
    chk("sat y_out", $signed(s_y), 32767);
    chk("sat overflow", s_ov, 1);
    chk("wrap y_valid", w_yv, 1);
    chk("wrap y_out", $signed(w_y), -1020);
    chk("wrap overflow", w_ov, 1);
    for (int i = 0; i < 4; i++) step(0, 1, 1, 1);
    chk("sat next y_out", $signed(s_y), 4);
    chk("sat next overflow", s_ov, 0);
    chk("wrap next y_out", $signed(w_y), 4);
    chk("wrap next overflow", w_ov, 0);

    // K_LEN=1 back-to-back
    async_reset();
    release_reset();
    step(0, 1, 2, 3);
    chk("k1 t0 y_valid", k_yv, 1);
    chk("k1 t0 y_out", $signed(k_y), 6);
    step(0, 1, -4, 4);
    chk("k1 t1 y_valid", k_yv, 1);
    chk("k1 t1 y_out", $signed(k_y), -16);
    step(0, 1, 7, -1);
    chk("k1 t2 y_valid", k_yv, 1);
    chk("k1 t2 y_out", $signed(k_y), -7);
    step(0, 0, 0, 0);
    chk("k1 idle y_valid", k_yv, 0);
    chk("k1 idle y_out", $signed(k_y), -7);
    chk("k1 idle overflow", k_ov, 0);
`ifdef PE_TILE_CNT_EN
    chk("k1 tile_cnt", k_tc, 3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
